// File: rtl/phase_pkg.sv
// -----------------------------------------------------------------------------
// phase_pkg
// Types and constants shared by the episode scheduler and its testbench.
//   state_t            : episode FSM states
//   SLOTS_PER_EPISODE  : gamma slots in one theta episode
//   LAST_SLOT          : gamma position of the final slot
// -----------------------------------------------------------------------------
package phase_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        PAD,
        WAIT_THETA
    } state_t;

    localparam int         SLOTS_PER_EPISODE = 8;
    localparam logic [2:0] LAST_SLOT         = 3'd7;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO, depth 2**AW.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   : write request and data (ignored when full)
//   pop           : read request (ignored when empty)
//   rdata         : head entry, valid whenever empty=0
//   full, empty   : occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/episode_scheduler.sv
// -----------------------------------------------------------------------------
// episode_scheduler
// Buffers upstream tokens and issues one token or one pad per gamma slot,
// grouping slots into theta episodes and reporting each episode's length.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | disabled; all ticks ignored
// ARM        | waiting for the slot-0 gamma tick to open an episode
// RUN        | each gamma tick pops a token (or pads on underrun)
// PAD        | sentence ended early; remaining slots are pads
// WAIT_THETA | all 8 slots issued; theta tick closes the episode
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   enable                      : allow new episodes to arm
//   gamma_tick, gamma_cnt       : gamma slot strobe and its position 0..7
//   theta_tick                  : episode boundary strobe
//   in_valid/in_ready/in_token/in_eos : upstream token handshake
//   slot_valid/slot_idx/slot_token/slot_pad : per-slot issue (registered)
//   episode_start               : pulses with slot 0
//   episode_done/episode_len/episode_trunc : episode close report
//   underrun                    : sticky, a RUN slot found the FIFO empty
// -----------------------------------------------------------------------------
module episode_scheduler
    import phase_pkg::*;
#(
    parameter int TOKEN_W = 16,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               gamma_tick,
    input  logic [2:0]         gamma_cnt,
    input  logic               theta_tick,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOKEN_W-1:0] in_token,
    input  logic               in_eos,
    output logic               slot_valid,
    output logic [2:0]         slot_idx,
    output logic [TOKEN_W-1:0] slot_token,
    output logic               slot_pad,
    output logic               episode_start,
    output logic               episode_done,
    output logic [3:0]         episode_len,
    output logic               episode_trunc,
    output logic               underrun
);

    state_t             state;
    state_t             state_nx;
    logic               fifo_full;
    logic               fifo_empty;
    logic [TOKEN_W:0]   fifo_rdata;
    logic               push;
    logic               pop;
    logic               pop_eos;
    logic               arm_start;
    logic               run_slot;
    logic               pad_slot;
    logic               close_ep;
    logic [3:0]         len_cnt;
    logic               last_eos;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;

    // The opening tick in ARM is handled exactly like a RUN slot.
    assign arm_start = (state == ARM) && gamma_tick && (gamma_cnt == 3'd0);
    assign run_slot  = ((state == RUN) && gamma_tick) || arm_start;
    assign pad_slot  = (state == PAD) && gamma_tick;
    assign pop       = run_slot && !fifo_empty;
    assign pop_eos   = fifo_rdata[TOKEN_W];
    assign close_ep  = (state == WAIT_THETA) && theta_tick;

    sync_fifo #(
        .WIDTH (TOKEN_W + 1),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_eos, in_token}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (enable) state_nx = ARM;
            end
            ARM, RUN: begin
                if (run_slot) begin
                    if (gamma_cnt == LAST_SLOT)  state_nx = WAIT_THETA;
                    else if (pop && pop_eos)     state_nx = PAD;
                    else                         state_nx = RUN;
                end else if (state == ARM && !enable) begin
                    state_nx = IDLE;
                end
            end
            PAD: begin
                if (pad_slot && gamma_cnt == LAST_SLOT) state_nx = WAIT_THETA;
            end
            WAIT_THETA: begin
                if (theta_tick) state_nx = enable ? ARM : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            slot_valid    <= 1'b0;
            slot_idx      <= 3'd0;
            slot_token    <= '0;
            slot_pad      <= 1'b0;
            episode_start <= 1'b0;
            episode_done  <= 1'b0;
            episode_len   <= 4'd0;
            episode_trunc <= 1'b0;
            underrun      <= 1'b0;
            len_cnt       <= 4'd0;
            last_eos      <= 1'b0;
        end else begin
            state         <= state_nx;
            slot_valid    <= run_slot || pad_slot;
            episode_start <= arm_start;
            episode_done  <= close_ep;

            if (run_slot || pad_slot) begin
                slot_idx   <= gamma_cnt;
                slot_pad   <= !pop;
                slot_token <= pop ? fifo_rdata[TOKEN_W-1:0] : '0;
            end

            if (run_slot && fifo_empty) underrun <= 1'b1;

            // last_eos tracks the most recent popped token; with 8 tokens
            // issued that is the slot-7 token.
            if (arm_start) begin
                len_cnt  <= pop ? 4'd1 : 4'd0;
                last_eos <= pop && pop_eos;
            end else if (pop) begin
                len_cnt  <= len_cnt + 4'd1;
                last_eos <= pop_eos;
            end

            if (close_ep) begin
                episode_len   <= len_cnt;
                episode_trunc <= (len_cnt == 4'(SLOTS_PER_EPISODE)) && !last_eos;
            end
        end
    end

endmodule
